// File: rtl/jtcontra_sndlatch_pkg.sv
// Shared constants for the sound latch: IRQ mode encodings, depth limit,
// and a helper that sizes FIFO pointers.
package jtcontra_sndlatch_pkg;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_PULSE = 1;
    localparam int MAX_DEPTH = 16;

    // Pointer width; a single-entry latch still carries a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/jtcontra_sndlatch_irq.sv
// Sound-CPU interrupt generator: either a level held until acknowledged or a
// fixed-length pulse restarted by every accepted write.
module jtcontra_sndlatch_irq
    import jtcontra_sndlatch_pkg::*;
#(
    parameter int IRQ_MODE = IRQ_LEVEL,
    parameter int IRQ_LEN  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic set_i,
    input  logic ack_i,
    output logic irq_o
);

    generate
        if (IRQ_MODE == IRQ_PULSE) begin : g_pulse
            logic [7:0] cnt_q, cnt_d;
            logic       irq_q, irq_d;

            // A new write reloads the count; ack cuts the pulse short.
            always_comb begin
                cnt_d = cnt_q;
                if (set_i) begin
                    cnt_d = 8'(IRQ_LEN);
                end else if (ack_i) begin
                    cnt_d = '0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
                irq_d = (cnt_d != 8'd0);
            end

            // Counter and registered IRQ output.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                    irq_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    irq_q <= irq_d;
                end
            end

            assign irq_o = irq_q;
        end else begin : g_level
            logic irq_q, irq_d;

            // Set wins over a same-cycle acknowledge.
            always_comb begin
                irq_d = irq_q;
                if (set_i) begin
                    irq_d = 1'b1;
                end else if (ack_i) begin
                    irq_d = 1'b0;
                end
            end

            // Registered level IRQ.
            always_ff @(posedge clk) begin
                if (rst) begin
                    irq_q <= 1'b0;
                end else begin
                    irq_q <= irq_d;
                end
            end

            assign irq_o = irq_q;
        end
    endgenerate

endmodule

// File: rtl/jtcontra_sndlatch.sv
// Main-CPU to sound-CPU command latch. DEPTH=1 behaves as a classic latch
// (overwrite on full); larger depths form a FIFO that drops writes on full.
module jtcontra_sndlatch
    import jtcontra_sndlatch_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DEPTH    = 1,
    parameter int IRQ_MODE = IRQ_LEVEL,
    parameter int IRQ_LEN  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [DW-1:0]            din,
    input  logic                     rd,
    input  logic                     irq_ack,
    input  logic                     ovf_clr,
    output logic [DW-1:0]            dout,
    output logic                     snd_irq,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int AW = ptr_w(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          pop, push, overwrite, ovf_evt, accept;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    // Next-state: a pop frees a slot so a same-cycle push on a full buffer
    // succeeds; dout is taken from the post-update head so it is current
    // one cycle after the strobe, and holds when the buffer drains.
    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        pop       = rd && !empty_q;
        push      = wr && (!full_q || pop);
        overwrite = (DEPTH == 1) && wr && !push;
        ovf_evt   = wr && !push;
        accept    = push || overwrite;
        if (accept) begin
            mem_d[wr_ptr_q] = din;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
        dout_d  = empty_d ? dout_q : mem_d[rd_ptr_d];
        ovf_d   = ovf_q;
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers; reset clears pointers, flags and the visible data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    jtcontra_sndlatch_irq #(
        .IRQ_MODE (IRQ_MODE),
        .IRQ_LEN  (IRQ_LEN)
    ) u_irq (
        .clk   (clk),
        .rst   (rst),
        .set_i (accept),
        .ack_i (irq_ack),
        .irq_o (snd_irq)
    );

    assign dout  = dout_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign level = level_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_jtcontra_sndlatch.sv
// Bench for the sound latch: three instances (single-entry latch, 4-deep
// level-IRQ FIFO, 4-deep pulse-IRQ FIFO) share one stimulus stream and are
// compared each cycle against a queue-based reference model.
module tb_jtcontra_sndlatch;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, wr = 1'b0, rd = 1'b0, irq_ack = 1'b0, ovf_clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout0, dout1, dout2;
    logic       irq0, irq1, irq2, empty0, empty1, empty2;
    logic       full0, full1, full2, ovf0, ovf1, ovf2;
    logic [0:0] lvl0;
    logic [2:0] lvl1, lvl2;

    jtcontra_sndlatch #(.DW(8), .DEPTH(1), .IRQ_MODE(0), .IRQ_LEN(16)) u_d1 (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .irq_ack(irq_ack),
        .ovf_clr(ovf_clr), .dout(dout0), .snd_irq(irq0), .empty(empty0),
        .full(full0), .level(lvl0), .ovf(ovf0));

    jtcontra_sndlatch #(.DW(8), .DEPTH(4), .IRQ_MODE(0), .IRQ_LEN(16)) u_d4 (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .irq_ack(irq_ack),
        .ovf_clr(ovf_clr), .dout(dout1), .snd_irq(irq1), .empty(empty1),
        .full(full1), .level(lvl1), .ovf(ovf1));

    jtcontra_sndlatch #(.DW(8), .DEPTH(4), .IRQ_MODE(1), .IRQ_LEN(16)) u_p (
        .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .irq_ack(irq_ack),
        .ovf_clr(ovf_clr), .dout(dout2), .snd_irq(irq2), .empty(empty2),
        .full(full2), .level(lvl2), .ovf(ovf2));

    logic [7:0] a_dout [3];
    logic [2:0] a_lvl  [3];
    logic       a_irq  [3], a_empty [3], a_full [3], a_ovf [3];
    assign a_dout[0] = dout0;  assign a_dout[1] = dout1;  assign a_dout[2] = dout2;
    assign a_lvl[0]  = {2'b00, lvl0}; assign a_lvl[1] = lvl1; assign a_lvl[2] = lvl2;
    assign a_irq[0]  = irq0;   assign a_irq[1]  = irq1;   assign a_irq[2]  = irq2;
    assign a_empty[0] = empty0; assign a_empty[1] = empty1; assign a_empty[2] = empty2;
    assign a_full[0] = full0;  assign a_full[1] = full1;  assign a_full[2] = full2;
    assign a_ovf[0]  = ovf0;   assign a_ovf[1]  = ovf1;   assign a_ovf[2]  = ovf2;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending entries are plain queues; instance 0 is single-entry, 1 and 2 hold four.
    logic [7:0] q0[$], q1[$], q2[$];
    logic [7:0] m_dout [3] = '{8'h00, 8'h00, 8'h00};
    bit         m_ovf  [3] = '{0, 0, 0};
    bit         m_irq  [3] = '{0, 0, 0};
    int         m_cnt  [3] = '{0, 0, 0};

    task automatic model_step(input int k, input bit r, input bit w, input logic [7:0] d,
                              input bit rdv, input bit ak, input bit cl);
        logic [7:0] cur[$];
        int dep;
        bit acc, oe;
        dep = (k == 0) ? 1 : 4;
        if (k == 0) cur = q0; else if (k == 1) cur = q1; else cur = q2;
        acc = 0;
        oe  = 0;
        if (r) begin
            cur.delete();
            m_dout[k] = 8'h00;
            m_ovf[k]  = 0;
            m_irq[k]  = 0;
            m_cnt[k]  = 0;
        end else begin
            if (rdv && cur.size() > 0) void'(cur.pop_front());
            if (w) begin
                if (cur.size() < dep) begin
                    cur.push_back(d);
                    acc = 1;
                end else if (dep == 1) begin
                    cur[0] = d;
                    acc = 1;
                    oe  = 1;
                end else begin
                    oe = 1;
                end
            end
            if (cur.size() > 0) m_dout[k] = cur[0];
            if (oe) m_ovf[k] = 1;
            else if (cl) m_ovf[k] = 0;
            if (k == 2) begin
                if (acc) m_cnt[k] = 16;
                else if (ak) m_cnt[k] = 0;
                else if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                m_irq[k] = (m_cnt[k] > 0);
            end else begin
                if (acc) m_irq[k] = 1;
                else if (ak) m_irq[k] = 0;
            end
        end
        if (k == 0) q0 = cur; else if (k == 1) q1 = cur; else q2 = cur;
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            int sz, dep;
            dep = (k == 0) ? 1 : 4;
            if (k == 0) sz = q0.size(); else if (k == 1) sz = q1.size(); else sz = q2.size();
            chk($sformatf("u%0d dout", k),  a_dout[k],  m_dout[k]);
            chk($sformatf("u%0d level", k), a_lvl[k],   sz);
            chk($sformatf("u%0d empty", k), a_empty[k], (sz == 0) ? 1 : 0);
            chk($sformatf("u%0d full", k),  a_full[k],  (sz == dep) ? 1 : 0);
            chk($sformatf("u%0d ovf", k),   a_ovf[k],   m_ovf[k]);
            chk($sformatf("u%0d irq", k),   a_irq[k],   m_irq[k]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit w, input logic [7:0] d,
                        input bit rdv, input bit ak, input bit cl);
        rst = r; wr = w; din = d; rd = rdv; irq_ack = ak; ovf_clr = cl;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, r, w, d, rdv, ak, cl);
        #1;
        check_model();
    endtask

    // ---------------- vector table (expectations for the 4-deep level-IRQ instance) ----------------
    typedef struct {
        bit r, w; logic [7:0] d; bit rdv, ak, cl;
        logic [7:0] e_dout; int e_lvl; bit e_full, e_empty, e_ovf, e_irq;
    } vec_t;

    function automatic vec_t mk(bit r, bit w, logic [7:0] d, bit rdv, bit ak, bit cl,
                                logic [7:0] ed, int el, bit ef, bit ee, bit eo, bit ei);
        vec_t v;
        v.r = r; v.w = w; v.d = d; v.rdv = rdv; v.ak = ak; v.cl = cl;
        v.e_dout = ed; v.e_lvl = el; v.e_full = ef; v.e_empty = ee; v.e_ovf = eo; v.e_irq = ei;
        return v;
    endfunction

    vec_t tbl [24];

    initial begin
        tbl[0]  = mk(1, 0, 8'h00, 0, 0, 0,  8'h00, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 1, 8'h01, 0, 0, 0,  8'h01, 1, 0, 0, 0, 1);
        tbl[2]  = mk(0, 1, 8'h02, 0, 0, 0,  8'h01, 2, 0, 0, 0, 1);
        tbl[3]  = mk(0, 1, 8'h03, 0, 0, 0,  8'h01, 3, 0, 0, 0, 1);
        tbl[4]  = mk(0, 1, 8'h04, 0, 0, 0,  8'h01, 4, 1, 0, 0, 1);
        tbl[5]  = mk(0, 1, 8'h05, 0, 0, 0,  8'h01, 4, 1, 0, 1, 1);
        tbl[6]  = mk(0, 0, 8'h00, 1, 0, 0,  8'h02, 3, 0, 0, 1, 1);
        tbl[7]  = mk(0, 0, 8'h00, 1, 0, 0,  8'h03, 2, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 8'h00, 1, 0, 0,  8'h04, 1, 0, 0, 1, 1);
        tbl[9]  = mk(0, 0, 8'h00, 1, 0, 0,  8'h04, 0, 0, 1, 1, 1);
        tbl[10] = mk(0, 0, 8'h00, 1, 0, 0,  8'h04, 0, 0, 1, 1, 1);
        tbl[11] = mk(0, 0, 8'h00, 0, 1, 0,  8'h04, 0, 0, 1, 1, 0);
        tbl[12] = mk(0, 0, 8'h00, 0, 0, 1,  8'h04, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 1, 8'h11, 1, 0, 0,  8'h11, 1, 0, 0, 0, 1);
        tbl[14] = mk(0, 1, 8'h22, 0, 0, 0,  8'h11, 2, 0, 0, 0, 1);
        tbl[15] = mk(0, 1, 8'h33, 0, 0, 0,  8'h11, 3, 0, 0, 0, 1);
        tbl[16] = mk(0, 1, 8'h44, 0, 0, 0,  8'h11, 4, 1, 0, 0, 1);
        tbl[17] = mk(0, 1, 8'hAA, 1, 0, 0,  8'h22, 4, 1, 0, 0, 1);
        tbl[18] = mk(0, 1, 8'h55, 0, 1, 1,  8'h22, 4, 1, 0, 1, 0);
        tbl[19] = mk(0, 0, 8'h00, 1, 0, 0,  8'h33, 3, 0, 0, 1, 0);
        tbl[20] = mk(0, 0, 8'h00, 1, 0, 0,  8'h44, 2, 0, 0, 1, 0);
        tbl[21] = mk(0, 0, 8'h00, 1, 0, 0,  8'hAA, 1, 0, 0, 1, 0);
        tbl[22] = mk(0, 0, 8'h00, 1, 0, 0,  8'hAA, 0, 0, 1, 1, 0);
        tbl[23] = mk(0, 1, 8'h5A, 0, 1, 0,  8'h5A, 1, 0, 0, 1, 1);

        // Table: FIFO fill/drop/drain, full wr+rd, same-cycle ack/clear rules.
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].rdv, tbl[i].ak, tbl[i].cl);
            chk($sformatf("tbl%0d dout", i),  dout1,  tbl[i].e_dout);
            chk($sformatf("tbl%0d level", i), lvl1,   tbl[i].e_lvl);
            chk($sformatf("tbl%0d full", i),  full1,  tbl[i].e_full);
            chk($sformatf("tbl%0d empty", i), empty1, tbl[i].e_empty);
            chk($sformatf("tbl%0d ovf", i),   ovf1,   tbl[i].e_ovf);
            chk($sformatf("tbl%0d irq", i),   irq1,   tbl[i].e_irq);
        end

        // Single-entry latch: overwrite sets ovf and raises IRQ; ack drops it.
        step(1, 0, 8'h00, 0, 0, 0);
        step(0, 1, 8'h22, 0, 0, 0);
        step(0, 1, 8'h33, 0, 0, 0);
        chk("latch dout", dout0, 8'h33);
        chk("latch ovf", ovf0, 1);
        chk("latch irq", irq0, 1);
        chk("latch full", full0, 1);
        step(0, 0, 8'h00, 1, 0, 0);
        chk("latch rd empty", empty0, 1);
        chk("latch rd keeps dout", dout0, 8'h33);
        step(0, 0, 8'h00, 0, 1, 0);
        chk("latch ack irq", irq0, 0);

        // Pulse IRQ: writes at cycles 0 and 8 keep the pulse high for cycles 1..24.
        step(1, 0, 8'h00, 0, 0, 0);
        for (int c = 0; c <= 30; c++) begin
            step(0, (c == 0 || c == 8), 8'h5C, 0, 0, 0);
            chk($sformatf("pulse cyc%0d", c + 1), irq2, (c + 1 >= 1 && c + 1 <= 24) ? 1 : 0);
        end
        step(0, 1, 8'h5D, 0, 0, 0);
        chk("pulse start", irq2, 1);
        step(0, 0, 8'h00, 0, 1, 0);
        chk("pulse ack ends", irq2, 0);

        // Reset mid-operation: level 3, ovf and IRQ pending, pulse running.
        step(1, 0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0, 0);
        step(0, 0, 8'h00, 1, 0, 0);
        chk("pre-rst level", lvl1, 3);
        chk("pre-rst ovf", ovf1, 1);
        chk("pre-rst irq", irq1, 1);
        chk("pre-rst pulse", irq2, 1);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 8'h77, 1, 0, 0);
            chk($sformatf("rst%0d level", i), lvl1, 0);
            chk($sformatf("rst%0d empty", i), empty1, 1);
            chk($sformatf("rst%0d dout", i), dout1, 0);
            chk($sformatf("rst%0d irq", i), irq1, 0);
            chk($sformatf("rst%0d ovf", i), ovf1, 0);
            chk($sformatf("rst%0d pulse", i), irq2, 0);
            chk($sformatf("rst%0d latch dout", i), dout0, 0);
        end
        step(0, 0, 8'h00, 1, 0, 0);
        chk("post-rst rd ignored", empty1, 1);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 6),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
